lane_array_pipe: RTL and testbench
==================================

// Module: lane_array_pipe
// PURPOSE
//  Parametrised N-lane transport pipeline between a producer and a consumer sub-block.
//  Carries a beat of {flag, field, packed lane array, unpacked lane array}.
//  Uses DEPTH valid/ready skid stages at full throughput, with a synchronous flush and an occupancy count.
//  Replaces the fixed 3-lane, point-to-point wiring between producer and consumer with a registered, back-pressurable path.
// PARAMETERS
//  NLANE  3  number of byte lanes in each array (>=1)
//  FW     2  width of the scalar field bus (>=1)
//  DEPTH  2  number of skid stages (>=1); each stage holds up to 2 beats
//  LREV   0  1: output lane i = input lane NLANE-1-i for both arrays; 0: lane order preserved
// PORTS
//  clk            in   1                   clock, rising edge
//  rst_n          in   1                   asynchronous active-low reset
//  flush          in   1                   synchronous discard of all held beats
//  in_valid       in   1                   producer beat valid
//  in_ready       out  1                   pipeline can accept a beat
//  in_flag        in   1                   scalar flag
//  in_field       in   [FW-1:0]            scalar field
//  in_packed      in   [0:NLANE-1][7:0]    packed lane array
//  in_unpacked    in   [7:0] x [0:NLANE-1] unpacked lane array
//  out_valid      out  1                   consumer beat valid
//  out_ready      in   1                   consumer accepts beat
//  out_flag       out  1                   scalar flag
//  out_field      out  [FW-1:0]            scalar field
//  out_packed     out  [0:NLANE-1][7:0]    packed lane array
//  out_unpacked   out  [7:0] x [0:NLANE-1] unpacked lane array
//  occupancy      out  [$clog2(2*DEPTH+1)-1:0]  beats currently held
// BEHAVIOUR
//  - Reset: in_ready=0 while rst_n=0 and 1 from the first clk edge after release.
//    All other outputs are 0 during reset: out_valid, occupancy, out_flag, out_field, out_packed, out_unpacked.
//  - Transfer: a beat moves when valid&&ready at a clk edge (in_ and out_ side independently).
//  - Payload must stay stable while valid=1 and ready=0; out_ payload is held until accepted.
//  - Latency: an accepted input appears on out_valid exactly DEPTH cycles later when the pipe is empty and out_ready=1.
//  - Throughput: 1 beat/cycle sustained with out_ready=1.
//  - Skid stage states: EMPTY -> (push) ONE; ONE -> (push&pop) ONE, (push only) TWO, (pop only) EMPTY; TWO -> (pop) ONE.
//    Stage ready = registered (state != TWO); no combinational ready path crosses stages.
//  - Full: occupancy == 2*DEPTH forces in_ready=0; in_valid is ignored.
//  - Empty: occupancy == 0 forces out_valid=0.
//  - Occupancy = accepted inputs minus accepted outputs.
//    A simultaneous push and pop leaves it unchanged.
//  - Ordering is strictly FIFO; no beat is ever dropped or duplicated except on flush.
//  - flush=1: at that edge every stage goes EMPTY and occupancy becomes 0.
//    Flush wins over a simultaneous push or pop: neither is counted and the pushed beat is discarded.
//    In the cycle after flush, out_valid=0 and in_ready=1.
//  - LREV applies only to lane indices; flag and field pass through unchanged; reversal is a pure wiring permutation.
//  - Reset asserted mid-stream: all beats lost asynchronously and outputs return to reset values immediately.
// CONFIGURATION
//  LANE_ARRAY_PIPE_PARITY_EN defined:
//    - Adds in_par [NLANE-1:0] (even parity per in_packed lane), err_lane [NLANE-1:0] out, and err_clr in.
//    - On each accepted beat, a lane whose ^{byte,par} != 0 sets a sticky err_lane bit; err_lane resets to 0.
//    - The failing beat still passes through unmodified.
//    - err_clr clears all bits; a set occurring on the same edge as err_clr wins.
//  LANE_ARRAY_PIPE_PARITY_EN undefined:
//    - in_par, err_lane and err_clr do not exist; no parity logic.
// STRUCTURE
//  - Package lane_array_pipe_pkg holds:
//    - typedef lane_t = logic [7:0]
//    - typedef beat_t: the packed struct {flag, field, packed lanes}
//    - function rev_lanes()
//    - localparam STAGE_CAP = 2
//  - Unpacked lanes are flattened into the stage payload and rebuilt at the output.
//  - Sub-module lane_pipe_stage: one 2-entry skid buffer, parametrised on payload width; instantiated DEPTH times in a generate loop.
// TESTING
//  T1 NLANE=3, DEPTH=2, out_ready=1:
//     in_packed={8'h11,8'h22,8'h33}, in_flag=1, field=2'b10 at cycle 0
//     -> out_valid=1 at cycle 2 with the identical payload; occupancy returns to 0.
//  T2 out_ready=0, 6 beats offered:
//     -> 4 accepted, in_ready=0, occupancy=4.
//     Then out_ready=1 -> beats drain in order 0..3 on consecutive cycles, and beats 4-5 follow.
//  T3 occupancy=3, flush and in_valid asserted on the same edge:
//     -> occupancy=0 and out_valid=0 next cycle; the flushed-cycle beat never appears.
//  T4 LREV=1: in_unpacked[0..2]={A0,B1,C2} -> out_unpacked[0..2]={C2,B1,A0}; flag and field unchanged.
//  T5 random valid/ready (10k beats) against a scoreboard -> zero loss, reordering or duplication; occupancy matches the model every cycle.
//  T6 PARITY_EN: lane1 sent with bad parity -> err_lane=3'b010 sticky and the beat delivered intact; err_clr -> 3'b000.

Source files
------------

// File: rtl/lane_array_pipe_pkg.sv
// Shared types and helpers for the lane_array_pipe transport pipeline.
package lane_array_pipe_pkg;

    typedef logic [7:0] lane_t;

    localparam int STAGE_CAP = 2;

    // Beat shape for the default 3-lane, 2-bit-field build; the top builds the
    // width-parametrised equivalent locally from the same lane_t.
    localparam int DEF_NLANE = 3;
    localparam int DEF_FW    = 2;

    typedef struct packed {
        logic                    flag;
        logic [DEF_FW-1:0]       field;
        lane_t [0:DEF_NLANE-1]   lanes;
    } beat_t;

    // Source lane feeding output lane idx.
    function automatic int rev_lanes(input int idx, input int nlane, input bit rev);
        return rev ? (nlane - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/lane_array_pipe_stage.sv
// lane_pipe_stage: one 2-entry valid/ready skid buffer with a registered ready.
module lane_pipe_stage
    import lane_array_pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    // state    | meaning
    // ST_EMPTY | no beat held
    // ST_ONE   | head beat in main_q
    // ST_TWO   | head in main_q, next beat in skid_q; not ready
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          push, pop;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/lane_array_pipe.sv
// N-lane back-pressurable transport pipeline built from DEPTH skid stages.
// Optional per-lane parity checking is enabled by LANE_ARRAY_PIPE_PARITY_EN.
module lane_array_pipe
    import lane_array_pipe_pkg::*;
#(
    parameter int NLANE = 3,
    parameter int FW    = 2,
    parameter int DEPTH = 2,
    parameter int LREV  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_flag,
    input  logic [FW-1:0]                  in_field,
    input  logic [0:NLANE-1][7:0]          in_packed,
    input  logic [7:0]                     in_unpacked [0:NLANE-1],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_flag,
    output logic [FW-1:0]                  out_field,
    output logic [0:NLANE-1][7:0]          out_packed,
    output logic [7:0]                     out_unpacked [0:NLANE-1],
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
`ifdef LANE_ARRAY_PIPE_PARITY_EN
    ,
    input  logic [NLANE-1:0]               in_par,
    input  logic                           err_clr,
    output logic [NLANE-1:0]               err_lane
`endif
);

    typedef struct packed {
        logic                flag;
        logic [FW-1:0]       field;
        lane_t [0:NLANE-1]   pk;
        lane_t [0:NLANE-1]   up;
    } pl_t;

    localparam int PW   = $bits(pl_t);
    localparam int OW   = $clog2(2*DEPTH+1);
    localparam int FULL = STAGE_CAP * DEPTH;

    pl_t           in_pl, out_pl;
    logic          s_valid [0:DEPTH];
    logic          s_ready [0:DEPTH];
    logic [PW-1:0] s_data  [0:DEPTH];
    logic [OW-1:0] occ_q, occ_d;
    logic          rdy_en_q, rdy_en_d;
    logic          push, pop;

    always_comb begin
        in_pl.flag  = in_flag;
        in_pl.field = in_field;
        in_pl.pk    = in_packed;
        for (int i = 0; i < NLANE; i++) begin
            in_pl.up[i] = in_unpacked[i];
        end
    end

    // Held low through reset and until the first edge after release.
    assign in_ready   = rdy_en_q && s_ready[0] && (occ_q != OW'(FULL));
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign s_valid[0]     = push;
    assign s_data[0]      = in_pl;
    assign s_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        lane_pipe_stage #(.PW(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (s_valid[g]),
            .in_ready  (s_ready[g]),
            .in_data   (s_data[g]),
            .out_valid (s_valid[g+1]),
            .out_ready (s_ready[g+1]),
            .out_data  (s_data[g+1])
        );
    end

    assign out_valid = s_valid[DEPTH];
    assign out_pl    = s_data[DEPTH];
    assign out_flag  = out_pl.flag;
    assign out_field = out_pl.field;

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        localparam int SRC = rev_lanes(g, NLANE, LREV != 0);
        assign out_packed[g]   = out_pl.pk[SRC];
        assign out_unpacked[g] = out_pl.up[SRC];
    end

    always_comb begin
        rdy_en_d = 1'b1;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    assign occupancy = occ_q;

`ifdef LANE_ARRAY_PIPE_PARITY_EN
    logic [NLANE-1:0] err_q, err_d, bad;

    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            bad[i] = ^{in_packed[i], in_par[i]};
        end
        err_d = err_clr ? '0 : err_q;
        // A flushed beat is discarded, so its parity is not recorded either.
        if (push && !flush) begin
            err_d = err_d | bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_lane = err_q;
`endif

endmodule

// File: tb/tb_lane_array_pipe.sv
// Scoreboard bench for lane_array_pipe: one lane-preserving and one lane-reversing instance.
module tb_lane_array_pipe;

    localparam int NLANE = 3;
    localparam int FW    = 2;
    localparam int DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_flag = 1'b0;
    logic                  out_ready = 1'b0;
    logic [FW-1:0]         in_field = '0;
    logic [0:NLANE-1][7:0] in_packed = '0;
    logic [7:0]            in_unpacked [0:NLANE-1];

    logic                  in_ready, in_ready_r;
    logic                  out_valid, out_valid_r;
    logic                  out_flag, out_flag_r;
    logic [FW-1:0]         out_field, out_field_r;
    logic [0:NLANE-1][7:0] out_packed, out_packed_r;
    logic [7:0]            out_unpacked [0:NLANE-1];
    logic [7:0]            out_unpacked_r [0:NLANE-1];
    logic [2:0]            occupancy, occupancy_r;

    always #5 clk = ~clk;

    lane_array_pipe #(.NLANE(NLANE), .FW(FW), .DEPTH(DEPTH), .LREV(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_flag(in_flag), .in_field(in_field),
        .in_packed(in_packed), .in_unpacked(in_unpacked),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_flag(out_flag), .out_field(out_field),
        .out_packed(out_packed), .out_unpacked(out_unpacked),
        .occupancy(occupancy)
    );

    lane_array_pipe #(.NLANE(NLANE), .FW(FW), .DEPTH(DEPTH), .LREV(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_r),
        .in_flag(in_flag), .in_field(in_field),
        .in_packed(in_packed), .in_unpacked(in_unpacked),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .out_flag(out_flag_r), .out_field(out_field_r),
        .out_packed(out_packed_r), .out_unpacked(out_unpacked_r),
        .occupancy(occupancy_r)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          nout = 0;
    logic [63:0] q [$];
    logic        ir_s, ov_s, ovr_s, acc_s;
    logic [63:0] obs_s, obsr_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Layout: {flag, field, pk0, pk1, pk2, up0, up1, up2}
    function automatic logic [63:0] pack_in();
        return {13'b0, in_flag, in_field, in_packed,
                in_unpacked[0], in_unpacked[1], in_unpacked[2]};
    endfunction

    function automatic logic [63:0] obs_out();
        return {13'b0, out_flag, out_field, out_packed,
                out_unpacked[0], out_unpacked[1], out_unpacked[2]};
    endfunction

    function automatic logic [63:0] obs_out_r();
        return {13'b0, out_flag_r, out_field_r, out_packed_r,
                out_unpacked_r[0], out_unpacked_r[1], out_unpacked_r[2]};
    endfunction

    function automatic logic [63:0] rev_pl(input logic [63:0] p);
        logic [63:0] r;
        r = p;
        for (int i = 0; i < 3; i++) begin
            r[47-8*i -: 8] = p[47-8*(2-i) -: 8];
            r[23-8*i -: 8] = p[23-8*(2-i) -: 8];
        end
        return r;
    endfunction

    task automatic set_rand_beat();
        in_flag  = 1'($urandom);
        in_field = 2'($urandom);
        for (int i = 0; i < NLANE; i++) begin
            in_packed[i]   = 8'($urandom);
            in_unpacked[i] = 8'($urandom);
        end
    endtask

    // One clock: sample and score at the falling edge, then let the rising edge act.
    task automatic step();
        @(negedge clk);
        ir_s   = in_ready;
        ov_s   = out_valid;
        ovr_s  = out_valid_r;
        obs_s  = obs_out();
        obsr_s = obs_out_r();
        chk("occ", 64'(occupancy), 64'(q.size()));
        chk("occ_r", 64'(occupancy_r), 64'(q.size()));
        if (q.size() == 2*DEPTH) begin
            chk("full_rdy", 64'(in_ready), 64'(0));
            chk("full_rdy_r", 64'(in_ready_r), 64'(0));
        end
        if (q.size() == 0) chk("empty_ov", 64'(out_valid), 64'(0));
        if (out_valid) begin
            if (q.size() == 0) chk("unexp_out", 64'(out_valid), 64'(0));
            else chk("out_pl", obs_s, q[0]);
        end
        if (out_valid_r) begin
            if (q.size() == 0) chk("unexp_out_r", 64'(out_valid_r), 64'(0));
            else chk("out_pl_r", obsr_s, rev_pl(q[0]));
        end
        acc_s = in_valid && in_ready;
        if (out_valid && out_ready) nout++;
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (acc_s) q.push_back(pack_in());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, cyc, r0, sent;
        for (int i = 0; i < NLANE; i++) in_unpacked[i] = '0;

        // Reset values and release
        step();
        chk("rst_in_ready", 64'(ir_s), 64'(0));
        chk("rst_out_valid", 64'(ov_s), 64'(0));
        chk("rst_out_pl", obs_s, 64'(0));
        chk("rst_out_pl_r", obsr_s, 64'(0));
        rst_n = 1'b1;
        step();
        chk("rel_in_ready_pre", 64'(ir_s), 64'(0));
        step();
        chk("rel_in_ready", 64'(ir_s), 64'(1));

        // T1 latency
        out_ready = 1'b1;
        in_packed = {8'h11, 8'h22, 8'h33};
        in_unpacked[0] = 8'h44; in_unpacked[1] = 8'h55; in_unpacked[2] = 8'h66;
        in_flag = 1'b1; in_field = 2'b10; in_valid = 1'b1;
        step();
        chk("t1_acc", 64'(acc_s), 64'(1));
        chk("t1_c0_ov", 64'(ov_s), 64'(0));
        in_valid = 1'b0;
        step();
        chk("t1_c1_ov", 64'(ov_s), 64'(0));
        step();
        chk("t1_c2_ov", 64'(ov_s), 64'(1));
        step();
        chk("t1_c3_ov", 64'(ov_s), 64'(0));

        // T2 back-pressure then drain
        out_ready = 1'b0;
        k = 0;
        set_rand_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (acc_s) begin
                k++;
                if (k < 6) set_rand_beat(); else in_valid = 1'b0;
            end
        end
        chk("t2_accepted", 64'(k), 64'(4));
        chk("t2_in_ready", 64'(ir_s), 64'(0));
        chk("t2_occ", 64'(occupancy), 64'(4));
        out_ready = 1'b1;
        r0 = nout;
        cyc = 0;
        while (nout - r0 < 6 && cyc < 20) begin
            step();
            cyc++;
            if (acc_s) begin
                k++;
                if (k < 6) set_rand_beat(); else in_valid = 1'b0;
            end
        end
        chk("t2_drain_cycles", 64'(cyc), 64'(6));

        // T3 flush with simultaneous push
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_rand_beat();
            in_valid = 1'b1;
            step();
        end
        chk("t3_occ3", 64'(occupancy), 64'(3));
        set_rand_beat();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t3_ov", 64'(ov_s), 64'(0));
        chk("t3_in_ready", 64'(ir_s), 64'(1));
        out_ready = 1'b1;
        r0 = nout;
        repeat (6) step();
        chk("t3_no_ghost", 64'(nout - r0), 64'(0));

        // T4 lane reversal on the LREV=1 instance
        in_flag = 1'b1; in_field = 2'b01;
        in_packed = {8'h0A, 8'h0B, 8'h0C};
        in_unpacked[0] = 8'hA0; in_unpacked[1] = 8'hB1; in_unpacked[2] = 8'hC2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!ovr_s && cyc < 10);
        chk("t4_seen", 64'(ovr_s), 64'(1));
        chk("t4_up0", 64'(obsr_s[23:16]), 64'(8'hC2));
        chk("t4_up1", 64'(obsr_s[15:8]), 64'(8'hB1));
        chk("t4_up2", 64'(obsr_s[7:0]), 64'(8'hA0));
        chk("t4_pk0", 64'(obsr_s[47:40]), 64'(8'h0C));
        chk("t4_flag", 64'(obsr_s[50]), 64'(1));
        chk("t4_field", 64'(obsr_s[49:48]), 64'(2'b01));

        // T5 random traffic
        sent = 0;
        cyc = 0;
        r0 = nout;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                set_rand_beat();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            step();
            cyc++;
            if (acc_s) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("t5_sent", 64'(sent), 64'(10000));
        chk("t5_drain", 64'(q.size()), 64'(0));
        chk("t5_recv", 64'(nout - r0), 64'(10000));

        // Reset asserted mid-stream
        out_ready = 1'b0;
        set_rand_beat();
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ov", 64'(out_valid), 64'(0));
        chk("mrst_occ", 64'(occupancy), 64'(0));
        chk("mrst_ir", 64'(in_ready), 64'(0));
        chk("mrst_pl", obs_out(), 64'(0));
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        chk("mrst_rel_ir", 64'(ir_s), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
